// File: rtl/regfile_pkg.sv
// regfile_pkg: shared sizing defaults and typedefs for the fuzzycpu register file.
//   DEF_DATA_W / DEF_ADDR_W / DEF_NUM_RD : default generics for regfile_sb
//   DEF_DEPTH                            : number of architectural registers
package regfile_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_ADDR_W = 5;
    localparam int unsigned DEF_NUM_RD = 2;
    localparam int unsigned DEF_DEPTH  = 32'(1) << DEF_ADDR_W;

    typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
    typedef logic [DEF_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/regfile_sb_if.sv
// regfile_sb_if: read, writeback, reservation and scoreboard-status signals.
//   master : pipeline side (drives addresses, writeback and reservation requests)
//   slave  : register file side (returns read data, busy flags and scoreboard state)
interface regfile_sb_if
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned NUM_RD = DEF_NUM_RD
);
    localparam int unsigned DEPTH = 32'(1) << ADDR_W;

    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     rsv_en;
    logic [ADDR_W-1:0]        rsv_addr;
    logic                     rsv_ok;
    logic [DEPTH-1:0]         busy_vec;
    logic [ADDR_W:0]          busy_cnt;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
        input  rd_data, rd_busy, rsv_ok, busy_vec, busy_cnt
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
        output rd_data, rd_busy, rsv_ok, busy_vec, busy_cnt
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: busy-bit scoreboard with incrementally maintained popcount.
//   i_wr_en/i_wr_addr   : writeback releases the reservation of wr_addr
//   i_rsv_en/i_rsv_addr : issue-side reservation request
//   o_rsv_ok            : combinational grant (0 while in reset)
//   o_busy_vec          : registered busy bits, bit 0 is never set
//   o_busy_cnt          : registered popcount of o_busy_vec
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic              i_rsv_en,
    input  logic [ADDR_W-1:0] i_rsv_addr,
    output logic              o_rsv_ok,
    output logic [DEPTH-1:0]  o_busy_vec,
    output logic [ADDR_W:0]   o_busy_cnt
);
    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [DEPTH-1:0] r_busy;
    logic [CNT_W-1:0] r_cnt;

    logic             w_wr_hit;
    logic             w_same;
    logic             w_rsv_ok;
    logic             w_set;
    logic             w_inc;
    logic             w_dec;
    logic [DEPTH-1:0] w_busy_nxt;

    // Grant and next-state; a same-register release plus re-reserve nets to zero.
    always_comb begin
        w_wr_hit   = i_wr_en && (i_wr_addr != '0);
        w_same     = i_wr_en && (i_wr_addr == i_rsv_addr);
        w_rsv_ok   = rst_n && i_rsv_en &&
                     ((i_rsv_addr == '0) || !r_busy[i_rsv_addr] || w_same);
        w_set      = w_rsv_ok && (i_rsv_addr != '0);
        w_inc      = w_set && !r_busy[i_rsv_addr];
        w_dec      = w_wr_hit && r_busy[i_wr_addr] &&
                     !(w_set && (i_rsv_addr == i_wr_addr));
        w_busy_nxt = r_busy;
        if (w_wr_hit) begin
            w_busy_nxt[i_wr_addr] = 1'b0;
        end
        if (w_set) begin
            w_busy_nxt[i_rsv_addr] = 1'b1;
        end
    end

    // Busy bits and count; register 0 never sets, so the count tops out at DEPTH-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
            r_cnt  <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            r_cnt  <= r_cnt + CNT_W'(w_inc) - CNT_W'(w_dec);
        end
    end

    assign o_rsv_ok   = w_rsv_ok;
    assign o_busy_vec = r_busy;
    assign o_busy_cnt = r_cnt;

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: multi-read-port register file with busy-bit scoreboard.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : regfile_sb_if.slave (read ports, writeback, reservation, status)
// Optional build macro REGFILE_BYPASS_EN: forwards a same-cycle writeback to
// matching read ports (data = wr_data, busy = 0).
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned NUM_RD = DEF_NUM_RD
) (
    input  logic         clk,
    input  logic         rst_n,
    regfile_sb_if.slave  bus
);
    localparam int unsigned DEPTH = 32'(1) << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  w_busy_vec;
    logic              w_rsv_ok;
    logic [ADDR_W:0]   w_busy_cnt;

    // Storage; entry 0 is reset and never written, so it always reads 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[ADDR_W'(i)] <= '0;
            end
        end else if (bus.wr_en && (bus.wr_addr != '0)) begin
            r_mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    regfile_scoreboard #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_wr_en    (bus.wr_en),
        .i_wr_addr  (bus.wr_addr),
        .i_rsv_en   (bus.rsv_en),
        .i_rsv_addr (bus.rsv_addr),
        .o_rsv_ok   (w_rsv_ok),
        .o_busy_vec (w_busy_vec),
        .o_busy_cnt (w_busy_cnt)
    );

    assign bus.rsv_ok   = w_rsv_ok;
    assign bus.busy_vec = w_busy_vec;
    assign bus.busy_cnt = w_busy_cnt;

    // Per-port combinational read mux.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        logic [DATA_W-1:0] w_data;
        logic              w_busy;

        always_comb begin
            w_addr = bus.rd_addr[k*ADDR_W +: ADDR_W];
            w_data = r_mem[w_addr];
            w_busy = w_busy_vec[w_addr];
`ifdef REGFILE_BYPASS_EN
            // Forwarding is suppressed in reset so outputs read 0 immediately.
            if (rst_n && bus.wr_en && (bus.wr_addr != '0) && (w_addr == bus.wr_addr)) begin
                w_data = bus.wr_data;
                w_busy = 1'b0;
            end
`endif
        end

        assign bus.rd_data[k*DATA_W +: DATA_W] = w_data;
        assign bus.rd_busy[k]                  = w_busy;
    end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed plan plus randomized traffic against a behavioural model
// (register array + busy set) of regfile_sb with DATA_W=32, ADDR_W=5, NUM_RD=2.
module tb_regfile_sb;

    logic clk;
    logic rst_n;

    regfile_sb_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) bus ();

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: architectural values and the set of reserved registers.
    logic [31:0] m_mem [32];
    logic [31:0] m_busy;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_data(input logic [4:0] a, input logic wen,
                                             input logic [4:0] wa, input logic [31:0] wd);
        if (a == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
        if (wen && wa != 5'd0 && a == wa) return wd;
`endif
        return m_mem[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a, input logic wen, input logic [4:0] wa);
`ifdef REGFILE_BYPASS_EN
        if (wen && wa != 5'd0 && a == wa) return 1'b0;
`endif
        return m_busy[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_mem[i] = 32'd0;
        m_busy = 32'd0;
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic cycle(input logic wen, input logic [4:0] wa, input logic [31:0] wd,
                         input logic ren, input logic [4:0] ra,
                         input logic [4:0] a0, input logic [4:0] a1);
        logic ok;
        bus.wr_en    = wen;
        bus.wr_addr  = wa;
        bus.wr_data  = wd;
        bus.rsv_en   = ren;
        bus.rsv_addr = ra;
        bus.rd_addr  = {a1, a0};
        #2;
        ok = ren && (ra == 5'd0 || !m_busy[ra] || (wen && wa == ra));
        check("rsv_ok", 64'(bus.rsv_ok), 64'(ok));
        check("rd_data0", 64'(bus.rd_data[31:0]), 64'(exp_data(a0, wen, wa, wd)));
        check("rd_data1", 64'(bus.rd_data[63:32]), 64'(exp_data(a1, wen, wa, wd)));
        check("rd_busy0", 64'(bus.rd_busy[0]), 64'(exp_busy(a0, wen, wa)));
        check("rd_busy1", 64'(bus.rd_busy[1]), 64'(exp_busy(a1, wen, wa)));
        if (wen && wa != 5'd0) begin
            m_mem[wa]  = wd;
            m_busy[wa] = 1'b0;
        end
        if (ok && ra != 5'd0) m_busy[ra] = 1'b1;
        @(posedge clk);
        #1;
        check("busy_vec", 64'(bus.busy_vec), 64'(m_busy));
        check("busy_cnt", 64'(bus.busy_cnt), 64'($countones(m_busy)));
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.rsv_en = 1'b0; bus.rsv_addr = '0; bus.rd_addr = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_cnt", 64'(bus.busy_cnt), 64'd0);
        check("reset_vec", 64'(bus.busy_vec), 64'd0);
        rst_n = 1'b1;

        // Basic writes and reads.
        cycle(1'b1, 5'd0, 32'd5,  1'b0, 5'd0, 5'd0, 5'd0);
        cycle(1'b1, 5'd1, 32'd25, 1'b0, 5'd0, 5'd0, 5'd0);
        cycle(1'b1, 5'd2, 32'd35, 1'b0, 5'd0, 5'd0, 5'd0);
        cycle(1'b1, 5'd3, 32'd65, 1'b0, 5'd0, 5'd0, 5'd0);
        cycle(1'b0, 5'd0, 32'd0,  1'b0, 5'd0, 5'd1, 5'd2);
        cycle(1'b0, 5'd0, 32'd0,  1'b0, 5'd0, 5'd3, 5'd0);
        bus.rd_addr = {5'd2, 5'd1};
        #1;
        check("plan_r1", 64'(bus.rd_data[31:0]), 64'd25);
        check("plan_r2", 64'(bus.rd_data[63:32]), 64'd35);

        // Reserve r4, release via writeback.
        cycle(1'b0, 5'd0, 32'd0,    1'b1, 5'd4, 5'd4, 5'd0);
        cycle(1'b0, 5'd0, 32'd0,    1'b0, 5'd0, 5'd4, 5'd0);
        check("plan_cnt1", 64'(bus.busy_cnt), 64'd1);
        cycle(1'b1, 5'd4, 32'h99,   1'b0, 5'd0, 5'd4, 5'd0);
        cycle(1'b0, 5'd0, 32'd0,    1'b0, 5'd0, 5'd4, 5'd0);
        bus.rd_addr = {5'd0, 5'd4};
        #1;
        check("plan_r4", 64'(bus.rd_data[31:0]), 64'h99);

        // WAW stall, then same-cycle release plus re-reserve.
        cycle(1'b0, 5'd0, 32'd0,    1'b1, 5'd4, 5'd4, 5'd0);
        cycle(1'b0, 5'd0, 32'd0,    1'b1, 5'd4, 5'd4, 5'd0);
        cycle(1'b1, 5'd4, 32'hAB,   1'b1, 5'd4, 5'd4, 5'd0);
        cycle(1'b0, 5'd0, 32'd0,    1'b0, 5'd0, 5'd4, 5'd0);
        check("plan_cnt_rr", 64'(bus.busy_cnt), 64'd1);

        // Register 0 reservation and write are no-ops.
        cycle(1'b1, 5'd0, 32'd7,    1'b1, 5'd0, 5'd0, 5'd0);

        // Same-cycle write and read of r5.
        cycle(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 5'd5, 5'd5);
        cycle(1'b0, 5'd0, 32'd0,    1'b0, 5'd0, 5'd5, 5'd4);

        // Randomized traffic concentrated on a few registers to provoke hazards.
        for (int n = 0; n < 400; n++) begin
            cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
        end

        // Mid-cycle asynchronous reset after several reservations.
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd1, 5'd1, 5'd2);
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 5'd1, 5'd2);
        cycle(1'b1, 5'd3, 32'h55, 1'b1, 5'd3, 5'd1, 5'd2);
        bus.wr_en = 1'b0; bus.rsv_en = 1'b0;
        bus.rd_addr = {5'd3, 5'd1};
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_vec",   64'(bus.busy_vec), 64'd0);
        check("arst_cnt",   64'(bus.busy_cnt), 64'd0);
        check("arst_data0", 64'(bus.rd_data[31:0]), 64'd0);
        check("arst_data1", 64'(bus.rd_data[63:32]), 64'd0);
        check("arst_busy",  64'(bus.rd_busy), 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 5'd3, 5'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Safety net against a stalled run.
    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
